// File: rtl/button_conditioner_if.sv
// Board-facing bundle for the button conditioner: raw pins in, debounced levels and event pulses out.
// The master drives the raw pins and consumes the events. The slave is the conditioner itself.
interface button_conditioner_if;
  logic [4:0] btn_raw;
  logic       door_raw;
  logic [4:0] btn_level;
  logic [4:0] rise_button;
  logic [4:0] repeat_button;
  logic [1:0] door_history;

  modport master (
    output btn_raw,
    output door_raw,
    input  btn_level,
    input  rise_button,
    input  repeat_button,
    input  door_history
  );

  modport slave (
    input  btn_raw,
    input  door_raw,
    output btn_level,
    output rise_button,
    output repeat_button,
    output door_history
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronizes and debounces 5 buttons plus the door switch, and generates rise, auto-repeat and door-history events.
// Latency is 2+DEBOUNCE_CYCLES clocks from raw pin to level. Pulses coincide with the level change. There is no backpressure.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic                  clk,
  input  logic                  reset,
  button_conditioner_if.slave   bus
);

  localparam int NCH = 6;  // bits 4:0 are buttons, bit 5 is the door
  localparam int NBT = 5;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_TERM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] RD_TERM = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RP_TERM = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   sync1;
  logic [NCH-1:0]   sync2;
  logic [NCH-1:0]   stable_q;
  logic [NCH-1:0]   stable_d;
  logic [CNT_W-1:0] dcnt_q [NCH];
  logic [CNT_W-1:0] dcnt_d [NCH];

  logic [NBT-1:0]   level_d;
  logic [NBT-1:0]   rise_d;
  logic [NBT-1:0]   rise_q;
  logic [NBT-1:0]   rep_d;
  logic [NBT-1:0]   rep_q;
  rpt_state_t       rstate_q [NBT];
  rpt_state_t       rstate_d [NBT];
  logic [CNT_W-1:0] rcnt_q   [NBT];
  logic [CNT_W-1:0] rcnt_d   [NBT];

  logic [1:0]       door_hist_q;

  assign raw = {bus.door_raw, bus.btn_raw};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The level toggles only after DEBOUNCE_CYCLES consecutive disagreeing samples. Any agreement clears the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NCH; i++) begin
      dcnt_d[i] = '0;
      if (sync2[i] != stable_q[i]) begin
        if (dcnt_q[i] + ONE == DB_TERM) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < NCH; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  assign level_d = stable_d[NBT-1:0];
  assign rise_d  = level_d & ~stable_q[NBT-1:0];

  // The FSMs run on next-cycle levels, so registered pulses line up with the first cycle btn_level reads 1.
  always_comb begin
    rep_d = '0;
    for (int i = 0; i < NBT; i++) begin
      rstate_d[i] = rstate_q[i];
      rcnt_d[i]   = rcnt_q[i];
      if (!level_d[i]) begin
        rstate_d[i] = IDLE;
        rcnt_d[i]   = '0;
      end else begin
        case (rstate_q[i])
          IDLE: begin
            if (rise_d[i]) begin
              rstate_d[i] = DELAY;
              rcnt_d[i]   = '0;
              rep_d[i]    = 1'b1;
            end
          end
          DELAY: begin
            if (rcnt_q[i] + ONE == RD_TERM) begin
              rstate_d[i] = REPEAT;
              rcnt_d[i]   = '0;
              rep_d[i]    = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + ONE;
            end
          end
          REPEAT: begin
            if (rcnt_q[i] + ONE == RP_TERM) begin
              rcnt_d[i] = '0;
              rep_d[i]  = 1'b1;
            end else begin
              rcnt_d[i] = rcnt_q[i] + ONE;
            end
          end
          default: begin
            rstate_d[i] = IDLE;
            rcnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_q <= '0;
      rep_q  <= '0;
      for (int i = 0; i < NBT; i++) begin
        rstate_q[i] <= IDLE;
        rcnt_q[i]   <= '0;
      end
    end else begin
      rise_q <= rise_d;
      rep_q  <= rep_d;
      for (int i = 0; i < NBT; i++) begin
        rstate_q[i] <= rstate_d[i];
        rcnt_q[i]   <= rcnt_d[i];
      end
    end
  end

  // Bit 0 tracks the current door level and bit 1 holds the level from the previous cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      door_hist_q <= 2'b00;
    end else begin
      door_hist_q <= {stable_q[NCH-1], stable_d[NCH-1]};
    end
  end

  assign bus.btn_level     = stable_q[NBT-1:0];
  assign bus.rise_button   = rise_q;
  assign bus.repeat_button = rep_q;
  assign bus.door_history  = door_hist_q;

endmodule
